// File: rtl/time_to_temp_cal.sv
// Ramp-time to temperature converter: two-point linear interpolation with run-time writable
// calibration and an iterative restoring divider. Optional macro TIME_TO_TEMP_CAL_CLAMP_EN.
module time_to_temp_cal #(
    parameter int TIME_W      = 20,
    parameter int TEMP_W      = 10,
    parameter int SCALE       = 1000,
    parameter int CAL_LO_INIT = 508066,
    parameter int CAL_HI_INIT = 762679,
    parameter int ROUND       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TIME_W-1:0] down_ramp_time,
    input  logic              cal_we,
    input  logic              cal_sel,
    input  logic [TIME_W-1:0] cal_data,
    output logic              busy,
    output logic [TEMP_W-1:0] temp,
    output logic              oor_low,
    output logic              oor_high,
    output logic              cal_err,
    output logic              eoc
);
    localparam int SCALE_W = $clog2(SCALE + 1);
    localparam int NUM_W   = TIME_W + SCALE_W;
    localparam int CNT_W   = $clog2(NUM_W);
    localparam logic [NUM_W-1:0] SCALE_N = NUM_W'(SCALE);

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, DIV, DONE} state_t;

    state_t            state;
    logic [TIME_W-1:0] cal_lo, cal_hi;
    logic [TIME_W-1:0] t_r, lo_r, hi_r;
    logic [TIME_W-1:0] den_r, rem_r;
    logic [NUM_W-1:0]  quo_r;
    logic [CNT_W-1:0]  cnt;

    logic [TIME_W:0]   trial;
    logic              ge;
    logic [TIME_W-1:0] rem_nxt;
    logic [NUM_W-1:0]  quo_nxt;
    logic [TIME_W-1:0] diff, span;
    logic [NUM_W-1:0]  num;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        trial   = {rem_r, quo_r[NUM_W-1]};
        ge      = (trial >= {1'b0, den_r});
        rem_nxt = ge ? TIME_W'(trial - {1'b0, den_r}) : trial[TIME_W-1:0];
        quo_nxt = {quo_r[NUM_W-2:0], ge};
        diff    = t_r - lo_r;
        span    = hi_r - lo_r;
        num     = NUM_W'(diff) * SCALE_N;
        if (ROUND != 0)
            num = num + NUM_W'(span >> 1);
    end

    // Calibration writes are independent of the conversion FSM; conversions use a snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_lo <= TIME_W'(CAL_LO_INIT);
            cal_hi <= TIME_W'(CAL_HI_INIT);
        end else if (cal_we) begin
            if (cal_sel) cal_hi <= cal_data;
            else         cal_lo <= cal_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            t_r      <= '0;
            lo_r     <= '0;
            hi_r     <= '0;
            den_r    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            temp     <= '0;
            oor_low  <= 1'b0;
            oor_high <= 1'b0;
            cal_err  <= 1'b0;
            eoc      <= 1'b0;
        end else begin
            eoc <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    t_r   <= down_ramp_time;
                    lo_r  <= cal_lo;
                    hi_r  <= cal_hi;
                    busy  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: begin
                    if (hi_r <= lo_r) begin
                        cal_err  <= 1'b1;
                        oor_low  <= 1'b0;
                        oor_high <= 1'b0;
                        eoc      <= 1'b1;
                        state    <= DONE;
                    end else if (t_r <= lo_r) begin
                        cal_err  <= 1'b0;
                        oor_low  <= 1'b1;
                        oor_high <= 1'b0;
`ifdef TIME_TO_TEMP_CAL_CLAMP_EN
                        temp     <= '0;
`endif
                        eoc      <= 1'b1;
                        state    <= DONE;
                    end else if (t_r >= hi_r) begin
                        cal_err  <= 1'b0;
                        oor_low  <= 1'b0;
                        oor_high <= 1'b1;
`ifdef TIME_TO_TEMP_CAL_CLAMP_EN
                        temp     <= TEMP_W'(SCALE);
`endif
                        eoc      <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cal_err  <= 1'b0;
                        oor_low  <= 1'b0;
                        oor_high <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    quo_r <= num;
                    den_r <= span;
                    rem_r <= '0;
                    cnt   <= CNT_W'(NUM_W - 1);
                    state <= DIV;
                end
                DIV: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    // The final iteration publishes the full quotient at once.
                    if (cnt == '0) begin
                        temp  <= quo_nxt[TEMP_W-1:0];
                        eoc   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/time_to_temp_cal.md
Name: time_to_temp_cal

Overview:
Parametrised successor to the fixed-calibration ramp-time-to-temperature converter. It maps a down-ramp cycle count onto a 0..SCALE temperature code by linear interpolation between two calibration points. The calibration points are writable at run time. Division is done by an internal iterative restoring divider, so no vendor divider core is needed. Sits between the ramp timer and the display/UART path.

Parameters:
- TIME_W, 20, width of down_ramp_time and the calibration registers.
- TEMP_W, 10, width of temp; SCALE must be at most 2^TEMP_W-1.
- SCALE, 1000, output code at cal_hi (1000 = 0.1 C resolution over 0..100 C).
- CAL_LO_INIT, 508066, reset value of cal_lo (cycles at 0 C).
- CAL_HI_INIT, 762679, reset value of cal_hi (cycles at 100 C).
- ROUND, 0, 0 = truncate quotient, 1 = round half up.

Ports:
- clk, input, 1, single clock; all logic rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request conversion; sampled only when busy=0.
- down_ramp_time, input, TIME_W, cycle count; captured on the accepted start edge.
- cal_we, input, 1, calibration register write strobe.
- cal_sel, input, 1, 0 = cal_lo, 1 = cal_hi.
- cal_data, input, TIME_W, calibration write data.
- busy, output, 1, high from the accepted start until the eoc cycle, inclusive.
- temp, output, TEMP_W, last valid temperature code.
- oor_low, output, 1, last conversion had time <= cal_lo.
- oor_high, output, 1, last conversion had time >= cal_hi.
- cal_err, output, 1, last conversion found cal_hi <= cal_lo.
- eoc, output, 1, one-cycle end-of-conversion pulse.

Behaviour:
- Reset (async assert, sync release): temp=0, oor_low=0, oor_high=0, cal_err=0, eoc=0, busy=0, cal_lo=CAL_LO_INIT, cal_hi=CAL_HI_INIT, FSM in IDLE.
- Derived widths: SCALE_W=$clog2(SCALE+1), NUM_W=TIME_W+SCALE_W.
- The calibration registers are writable in any state. Each conversion uses a snapshot of cal_lo and cal_hi taken on its start edge. A write in the same cycle as start is not seen by that conversion.
- FSM states: IDLE, CHECK, LOAD, DIV, DONE.
- IDLE: if start=1, capture t, lo, hi; set busy=1; go to CHECK. If start=0, stay in IDLE.
- CHECK: evaluation order is cal_err, then oor_low, then oor_high.
  - If hi <= lo: set cal_err=1, clear both oor flags, go to DONE.
  - Else if t <= lo: set oor_low=1, go to DONE.
  - Else if t >= hi: set oor_high=1, go to DONE.
  - Else clear all three flags and go to LOAD.
- LOAD: num=(t-lo)*SCALE, plus (hi-lo)>>1 when ROUND=1; den=hi-lo; go to DIV.
- DIV: restoring division producing one quotient bit per cycle, MSB first, for NUM_W cycles, then go to DONE.
- DONE: eoc=1 for exactly one cycle. temp is updated only for an in-range conversion and takes quotient[TEMP_W-1:0]. busy=0 and the FSM returns to IDLE on the same edge.
- Latency, counted from the edge that accepts start:
  - Out-of-range or cal_err: eoc is high after the 2nd edge.
  - In-range: eoc is high after edge NUM_W+3.
- The quotient is always at most SCALE, so there is no overflow. temp is never partially updated.
- start while busy=1 is ignored; it is not queued. A new start is accepted in the cycle after eoc.
- Flags keep their value until the next CHECK.
- rst_n asserted mid-conversion: immediate return to reset values, no eoc, calibration returns to the INIT values.

Optional Feature:
- Macro: TIME_TO_TEMP_CAL_CLAMP_EN.
- Defined: an out-of-range conversion also writes temp, with 0 for oor_low and SCALE for oor_high. A cal_err conversion leaves temp unchanged.
- Undefined: temp holds its previous value on any out-of-range or cal_err conversion.

Test Plan:
- Default calibration, ROUND=0, t=635372 -> eoc at edge NUM_W+3, temp=499, all flags 0. Same t with ROUND=1 -> temp=500.
- t=508067 -> temp=0; t=762678 -> temp=999; in both cases no flags and busy high for exactly NUM_W+3 cycles.
- t=508066 -> oor_low=1 and eoc after 2 edges, temp unchanged (0 with CLAMP_EN). t=762679 -> oor_high=1, temp unchanged (1000 with CLAMP_EN).
- Write cal_lo=100 and cal_hi=1100, then t=600 -> temp=500. Write cal_hi=100 (equal to cal_lo), then start -> cal_err=1, eoc pulse, temp stays 500.
- start pulses on every cycle of a conversion, plus a cal_lo write mid-DIV -> only the first start is served, with the pre-write calibration; exactly one eoc.
- rst_n low during DIV iteration 5 -> all outputs 0, busy 0, no eoc. cal_lo reads back 508066 via the next conversion, t=635372 -> 499.
